// File: rtl/sum_serial_pkg.sv
// Shared definitions for the bit-serial adder: state encoding and width helpers.
package sum_serial_pkg;

  localparam int unsigned DEFAULT_N = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  // Bit-counter width; a 1-bit operand still needs a 1-bit counter.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sum_serial_if.sv
// Operand/result bundle between the operand source (master) and the serial adder (slave).
interface sum_serial_if
  import sum_serial_pkg::*;
#(
  parameter int unsigned N = DEFAULT_N
);

  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         ci;
  logic         busy;
  logic         done;
  logic [N-1:0] s;
  logic         co;

  modport master (output start, a, b, ci, input busy, done, s, co);
  modport slave  (input start, a, b, ci, output busy, done, s, co);

endinterface

// File: rtl/sum_serial_sum1b.sv
// One-bit full adder used as the single datapath slice of the serial adder.
module sum1b (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic so,
  output logic co
);

  assign so = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/sum_serial.sv
// Bit-serial N-bit adder: one full-adder slice, LSB first, carry held in a flop.
module sum_serial
  import sum_serial_pkg::*;
#(
  parameter int unsigned N = DEFAULT_N
) (
  input logic         clk,
  input logic         rst_n,
  sum_serial_if.slave bus
);

  localparam int unsigned CW = cnt_width(N);

  state_e        state;
  logic [N-1:0]  a_sh;
  logic [N-1:0]  b_sh;
  logic [N-1:0]  sum_sh;
  logic          carry;
  logic [CW-1:0] cnt;
  logic          busy_q;
  logic          done_q;
  logic [N-1:0]  s_q;
  logic          co_q;

  logic          so_fa;
  logic          co_fa;
  logic [N-1:0]  sum_next_c;

  sum1b u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .so (so_fa),
    .co (co_fa)
  );

  // New sum bit enters at the MSB so the full word is aligned after N shifts.
  assign sum_next_c = (sum_sh >> 1) | (N'(so_fa) << (N - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      s_q    <= '0;
      co_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        // FIN accepts a new start exactly like IDLE, giving back-to-back runs.
        IDLE, FIN: begin
          if (bus.start) begin
            a_sh   <= bus.a;
            b_sh   <= bus.b;
            carry  <= bus.ci;
            cnt    <= '0;
            sum_sh <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end else begin
            state  <= IDLE;
          end
        end
        RUN: begin
          carry  <= co_fa;
          sum_sh <= sum_next_c;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(N - 1)) begin
            s_q    <= sum_next_c;
            co_q   <= co_fa;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= FIN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.s    = s_q;
  assign bus.co   = co_q;

endmodule

// File: tb/tb_sum_serial.sv
// Scoreboard bench for sum_serial at N=8 and N=1 against {co,s} = a + b + ci.
module tb_sum_serial;

  localparam int NA = 8;
  localparam int NB = 1;

  typedef struct {
    logic [32:0] val;
    int          due;
  } sb_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;
  sb_t  qa[$];
  sb_t  qb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  sum_serial_if #(.N(NA)) bus_a ();
  sum_serial_if #(.N(NB)) bus_b ();

  sum_serial #(.N(NA)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  sum_serial #(.N(NB)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  task automatic chk(input string name, input logic [32:0] got, input logic [32:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // One observation cycle: busy window, done timing and result value for the oldest pending add.
  task automatic check_step(input string tag, input int n, input logic busy, input logic done,
                            input logic [32:0] act, input bit has, input sb_t f, output bit pop);
    bit exp_busy;
    bit exp_done;
    pop      = 1'b0;
    exp_busy = has && (cyc >= f.due - n) && (cyc < f.due);
    exp_done = has && (cyc == f.due);
    checks++;
    if (busy !== exp_busy) begin
      errors++;
      $display("FAIL %s_busy cyc=%0d got=%b want=%b", tag, cyc, busy, exp_busy);
    end
    if (done === 1'b1 || exp_done) begin
      checks++;
      if (done !== exp_done) begin
        errors++;
        $display("FAIL %s_done cyc=%0d got=%b want=%b", tag, cyc, done, exp_done);
      end
    end
    if (done === 1'b1) begin
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL %s_busy_with_done cyc=%0d got=%b want=0", tag, cyc, busy);
      end
    end
    if (exp_done) begin
      pop = 1'b1;
      checks++;
      if (act !== f.val) begin
        errors++;
        $display("FAIL %s_sum cyc=%0d got=%0h want=%0h", tag, cyc, act, f.val);
      end
    end
  endtask

  bit  has_a, pop_a, has_b, pop_b;
  sb_t f_a, f_b;

  always @(posedge clk) begin
    #1;
    has_a = qa.size() > 0;
    if (has_a) f_a = qa[0];
    else       f_a = '{val: 33'd0, due: 0};
    check_step("n8", NA, bus_a.busy, bus_a.done, 33'({bus_a.co, bus_a.s}), has_a, f_a, pop_a);
    if (pop_a) void'(qa.pop_front());
  end

  always @(posedge clk) begin
    #1;
    has_b = qb.size() > 0;
    if (has_b) f_b = qb[0];
    else       f_b = '{val: 33'd0, due: 0};
    check_step("n1", NB, bus_b.busy, bus_b.done, 33'({bus_b.co, bus_b.s}), has_b, f_b, pop_b);
    if (pop_b) void'(qb.pop_front());
  end

  task automatic wait_idle_a();
    int t = 0;
    while (bus_a.busy !== 1'b0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      checks++;
      errors++;
      $display("FAIL n8_idle_timeout got=busy want=idle");
    end
  endtask

  task automatic wait_idle_b();
    int t = 0;
    while (bus_b.busy !== 1'b0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      checks++;
      errors++;
      $display("FAIL n1_idle_timeout got=busy want=idle");
    end
  endtask

  // Called at a falling edge; start is sampled on the next rising edge.
  task automatic start_a(input logic [7:0] a, input logic [7:0] b, input logic ci);
    wait_idle_a();
    bus_a.a     = a;
    bus_a.b     = b;
    bus_a.ci    = ci;
    bus_a.start = 1'b1;
    qa.push_back('{val: 33'(a) + 33'(b) + 33'(ci), due: cyc + 1 + NA});
    @(negedge clk);
    bus_a.start = 1'b0;
  endtask

  task automatic start_b(input logic a, input logic b, input logic ci);
    wait_idle_b();
    bus_b.a     = a;
    bus_b.b     = b;
    bus_b.ci    = ci;
    bus_b.start = 1'b1;
    qb.push_back('{val: 33'(a) + 33'(b) + 33'(ci), due: cyc + 1 + NB});
    @(negedge clk);
    bus_b.start = 1'b0;
  endtask

  initial begin
    bus_a.start = 1'b0; bus_a.a = '0; bus_a.b = '0; bus_a.ci = 1'b0;
    bus_b.start = 1'b0; bus_b.a = '0; bus_b.b = '0; bus_b.ci = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_s_n8",  33'(bus_a.s),  33'd0);
    chk("rst_co_n8", 33'(bus_a.co), 33'd0);
    chk("rst_s_n1",  33'(bus_b.s),  33'd0);
    chk("rst_co_n1", 33'(bus_b.co), 33'd0);
    rst_n = 1'b1;
    @(negedge clk);

    start_a(8'h0F, 8'h01, 1'b0);
    start_a(8'hFF, 8'h01, 1'b0);
    start_a(8'hFF, 8'hFF, 1'b1);

    // Start request and operand changes mid-run must be ignored.
    start_a(8'h12, 8'h34, 1'b0);
    repeat (3) @(negedge clk);
    bus_a.a = 8'hFF; bus_a.b = 8'hFF; bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;

    // Reset mid-run aborts with no done pulse and clears the result.
    start_a(8'hAA, 8'h55, 1'b1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    qa.delete();
    @(negedge clk);
    chk("midrst_busy", 33'(bus_a.busy), 33'd0);
    chk("midrst_done", 33'(bus_a.done), 33'd0);
    chk("midrst_s",    33'(bus_a.s),    33'd0);
    chk("midrst_co",   33'(bus_a.co),   33'd0);
    rst_n = 1'b1;
    @(negedge clk);
    start_a(8'h01, 8'h01, 1'b0);

    // Back-to-back: start held through the done cycle is accepted from FIN.
    wait_idle_a();
    bus_a.a = 8'h33; bus_a.b = 8'h44; bus_a.ci = 1'b0; bus_a.start = 1'b1;
    qa.push_back('{val: 33'h77, due: cyc + 1 + NA});
    @(negedge clk);
    bus_a.a = 8'h80; bus_a.b = 8'h80;
    qa.push_back('{val: 33'h100, due: qa[qa.size()-1].due + NA + 1});
    repeat (NA + 1) @(negedge clk);
    bus_a.start = 1'b0;

    repeat (1000) begin
      start_a(8'($urandom), 8'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (1000) begin
      start_b(1'($urandom), 1'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    begin
      int t = 0;
      while ((qa.size() > 0 || qb.size() > 0) && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (t >= 200) begin
        checks++;
        errors++;
        $display("FAIL drain_timeout got=%0d pending want=0", qa.size() + qb.size());
      end
    end
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
